tl_ram_responder: RTL
=====================

TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 16, number of 64-bit words (power of two, 2..64).
REQ-003 Parameter BASE_ADDR, default 31'h1000_0000, byte base address (aligned to DEPTH*8).
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 auto_in_a_ready  output  1  A-channel ready.
REQ-007 auto_in_a_valid  input  1  A-channel valid.
REQ-008 auto_in_a_bits_opcode  input  3  0 PutFullData, 1 PutPartialData, 4 Get; others unsupported.
REQ-009 auto_in_a_bits_param  input  3  ignored.
REQ-010 auto_in_a_bits_size  input  4  log2 bytes.
REQ-011 auto_in_a_bits_source  input  3  requester ID.
REQ-012 auto_in_a_bits_address  input  31  byte address.
REQ-013 auto_in_a_bits_mask  input  8  byte lanes.
REQ-014 auto_in_a_bits_data  input  64  write data.
REQ-015 auto_in_a_bits_corrupt  input  1  write data poisoned.
REQ-016 auto_in_d_ready  input  1  D-channel ready.
REQ-017 auto_in_d_valid  output  1  D-channel valid.
REQ-018 auto_in_d_bits_opcode  output  3  0 AccessAck, 1 AccessAckData.
REQ-019 auto_in_d_bits_param  output  2  constant 0.
REQ-020 auto_in_d_bits_size  output  4  echo of A size.
REQ-021 auto_in_d_bits_source  output  3  echo of A source.
REQ-022 auto_in_d_bits_sink  output  1  constant 0.
REQ-023 auto_in_d_bits_denied  output  1  request refused.
REQ-024 auto_in_d_bits_data  output  64  read data.
REQ-025 auto_in_d_bits_corrupt  output  1  read data invalid.

Function
REQ-026 SHALL hold a single registered D response slot; auto_in_a_ready = !d_valid || auto_in_d_ready.
REQ-027 SHALL fire A on a_valid && a_ready; response is visible on D exactly one cycle after A fire.
REQ-028 SHALL treat a request as denied if address is outside [BASE_ADDR, BASE_ADDR+DEPTH*8), size > 3, opcode unsupported, or (Put and a_corrupt=1).
REQ-029 Word index SHALL be address[3+log2(DEPTH)-1:3]; address[2:0] and size do not restrict the lanes: Put writes exactly the lanes whose mask bit is set.
REQ-030 Get SHALL return opcode 1 with the full 64-bit word; denied Get returns data 0, denied=1, corrupt=1.
REQ-031 PutFull/PutPartial SHALL return opcode 0; a denied Put performs no write; unsupported opcode returns opcode 0, denied=1, corrupt=0.
REQ-032 Memory write SHALL occur on the A-fire edge; a Get fired the following cycle returns the new data.
REQ-033 While d_valid && !d_ready, all D fields SHALL remain stable and A SHALL stall.
REQ-034 D fire and A fire in the same cycle SHALL load the new response, keeping d_valid=1 with no bubble.
REQ-035 D fire without A fire SHALL clear d_valid the next cycle.

Reset
REQ-036 While reset=0: d_valid=0, all D fields 0, every memory word 0, auto_in_a_ready=1 (after reset releases, one cycle later at most).
REQ-037 Reset asserted mid-transaction SHALL drop any pending response immediately (asynchronous); it is not replayed.

Configuration
REQ-038 Macro TL_RAM_RESPONDER_PERF_EN defined: adds output perf_denied_count [15:0], incremented on each D fire with denied=1, saturating at 16'hFFFF, cleared by reset.
REQ-039 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-040 PutFull addr BASE+8, mask FF, data 0x1122334455667788, source 2 -> next cycle D opcode 0, source 2, denied 0; then Get BASE+8 -> opcode 1, data 0x1122334455667788.
REQ-041 PutPartial BASE+8 mask 0x0F data 0xFFFFFFFF_AAAAAAAA onto above word -> Get returns 0x11223344AAAAAAAA.
REQ-042 Get BASE+DEPTH*8 -> opcode 1, denied 1, corrupt 1, data 0; opcode 2 at BASE -> opcode 0, denied 1, memory unchanged.
REQ-043 d_ready held 0 for 5 cycles after a Get -> a_ready 0, D fields stable; d_ready=1 with new A valid -> back-to-back D responses, no bubble.
REQ-044 reset driven low while d_valid=1 -> d_valid 0 same cycle, Get BASE after release returns 0; with PERF_EN, three denied responses -> perf_denied_count = 3.

Source files
------------

// File: rtl/tl_ram_responder_if.sv
// rtl/tl_ram_responder_if.sv - TileLink-UL A/D channel bundle between requester and RAM responder
interface tl_ram_responder_if;
    logic        auto_in_a_ready;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [3:0]  auto_in_a_bits_size;
    logic [2:0]  auto_in_a_bits_source;
    logic [30:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;
    logic        auto_in_d_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [3:0]  auto_in_d_bits_size;
    logic [2:0]  auto_in_d_bits_source;
    logic        auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    modport master (
        input  auto_in_a_ready,
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
        output auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
        output auto_in_a_bits_data, auto_in_a_bits_corrupt,
        output auto_in_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
        input  auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
        input  auto_in_d_bits_data, auto_in_d_bits_corrupt
    );

    modport slave (
        output auto_in_a_ready,
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
        input  auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
        input  auto_in_a_bits_data, auto_in_a_bits_corrupt,
        input  auto_in_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
        output auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
        output auto_in_d_bits_data, auto_in_d_bits_corrupt
    );
endinterface

// File: rtl/tl_ram_responder.sv
// rtl/tl_ram_responder.sv - single-beat TileLink-UL RAM responder with one registered D slot
// Optional denied-response counter output enabled by TL_RAM_RESPONDER_PERF_EN.
module tl_ram_responder #(
    parameter int          DEPTH     = 16,
    parameter logic [30:0] BASE_ADDR = 31'h1000_0000
) (
    input  logic              clock,
    input  logic              reset,
    tl_ram_responder_if.slave bus
`ifdef TL_RAM_RESPONDER_PERF_EN
    ,
    output logic [15:0]       perf_denied_count
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]   mem [DEPTH];
    logic          a_fire;
    logic          d_fire;
    logic          is_get;
    logic          is_put;
    logic          in_range;
    logic          denied;
    logic [AW-1:0] idx;
    logic          unused_bits;

    assign bus.auto_in_a_ready = !bus.auto_in_d_valid || bus.auto_in_d_ready;
    assign a_fire = bus.auto_in_a_valid && bus.auto_in_a_ready;
    assign d_fire = bus.auto_in_d_valid && bus.auto_in_d_ready;

    // BASE_ADDR is aligned to the window size, so range check is a compare of the high bits
    assign in_range = bus.auto_in_a_bits_address[30:AW+3] == BASE_ADDR[30:AW+3];
    assign idx      = bus.auto_in_a_bits_address[AW+2:3];
    assign is_get   = bus.auto_in_a_bits_opcode == 3'd4;
    assign is_put   = bus.auto_in_a_bits_opcode == 3'd0 || bus.auto_in_a_bits_opcode == 3'd1;
    assign denied   = !in_range || (bus.auto_in_a_bits_size > 4'd3) || !(is_get || is_put)
                      || (is_put && bus.auto_in_a_bits_corrupt);

    assign unused_bits = ^{bus.auto_in_a_bits_param, bus.auto_in_a_bits_address[2:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.auto_in_d_valid        <= 1'b0;
            bus.auto_in_d_bits_opcode  <= 3'd0;
            bus.auto_in_d_bits_param   <= 2'd0;
            bus.auto_in_d_bits_size    <= 4'd0;
            bus.auto_in_d_bits_source  <= 3'd0;
            bus.auto_in_d_bits_sink    <= 1'b0;
            bus.auto_in_d_bits_denied  <= 1'b0;
            bus.auto_in_d_bits_data    <= 64'd0;
            bus.auto_in_d_bits_corrupt <= 1'b0;
        end else if (a_fire) begin
            bus.auto_in_d_valid        <= 1'b1;
            bus.auto_in_d_bits_opcode  <= is_get ? 3'd1 : 3'd0;
            bus.auto_in_d_bits_size    <= bus.auto_in_a_bits_size;
            bus.auto_in_d_bits_source  <= bus.auto_in_a_bits_source;
            bus.auto_in_d_bits_denied  <= denied;
            bus.auto_in_d_bits_data    <= (is_get && !denied) ? mem[idx] : 64'd0;
            bus.auto_in_d_bits_corrupt <= is_get && denied;
        end else if (d_fire) begin
            bus.auto_in_d_valid        <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
        end else if (a_fire && is_put && !denied) begin
            for (int b = 0; b < 8; b++)
                if (bus.auto_in_a_bits_mask[b]) mem[idx][8*b +: 8] <= bus.auto_in_a_bits_data[8*b +: 8];
        end
    end

`ifdef TL_RAM_RESPONDER_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_denied_count <= 16'd0;
        end else if (d_fire && bus.auto_in_d_bits_denied && perf_denied_count != 16'hFFFF) begin
            perf_denied_count <= perf_denied_count + 16'd1;
        end
    end
`endif
endmodule
